// File: rtl/debounced_pio_pkg.sv
// Shared constants for the debounced PIO input block: register addresses,
// debounce-count width and the "zero means one" count helper.
package debounced_pio_pkg;

  localparam int unsigned DB_CNT_W = 16;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_DB_CNT   = 3'd5;

  // A programmed count of 0 behaves like 1 so a channel can never stall.
  function automatic logic [DB_CNT_W-1:0] db_effective(input logic [DB_CNT_W-1:0] cnt);
    db_effective = (cnt == 16'd0) ? 16'd1 : cnt;
  endfunction

endpackage

// File: rtl/pio_debounce_ch.sv
// One input channel: synchroniser chain, optional debounce counter
// (DEBOUNCED_PIO_DEBOUNCE_EN) and rise/fall pulses of the stable state.
module pio_debounce_ch
  import debounced_pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_i,
  input  logic [DB_CNT_W-1:0] db_eff_i,
  input  logic                db_clr_i,
  output logic                stable_o,
  output logic                rise_o,
  output logic                fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic                   stable_s;
  logic                   prev_q;

  // Synchroniser chain for the asynchronous pad input.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCED_PIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] cnt_q;
  logic [DB_CNT_W-1:0] cnt_d;
  logic                stable_q;
  logic                stable_d;

  // Flip only after db_eff_i consecutive cycles of disagreement.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (db_clr_i) begin
      cnt_d = 16'd0;
    end else if (sync_s == stable_q) begin
      cnt_d = 16'd0;
    end else if ((cnt_q + 16'd1) >= db_eff_i) begin
      cnt_d    = 16'd0;
      stable_d = sync_s;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Debounce counter and stable-state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= 16'd0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_s = stable_q;
`else
  logic unused_s;
  assign unused_s = ^{db_eff_i, db_clr_i};
  assign stable_s = sync_s;
`endif

  // Previous stable value; both reset to 0 so reset itself never looks like an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= stable_s;
    end
  end

  assign stable_o = stable_s;
  assign rise_o   = stable_s & ~prev_q;
  assign fall_o   = ~stable_s & prev_q;

endmodule

// File: rtl/debounced_pio_in.sv
// Memory-mapped debounced PIO input with edge capture and level interrupt.
// Debouncing is built only when DEBOUNCED_PIO_DEBOUNCE_EN is defined.
module debounced_pio_in
  import debounced_pio_pkg::*;
#(
  parameter int                  WIDTH       = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [DB_CNT_W-1:0] DB_DEFAULT  = 16'd1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic                wr_s;
  logic [WIDTH-1:0]    stable_s;
  logic [WIDTH-1:0]    rise_s;
  logic [WIDTH-1:0]    fall_s;
  logic [WIDTH-1:0]    rise_en_q;
  logic [WIDTH-1:0]    fall_en_q;
  logic [WIDTH-1:0]    irq_mask_q;
  logic [WIDTH-1:0]    edge_cap_q;
  logic [WIDTH-1:0]    edge_cap_d;
  logic [31:0]         readdata_q;
  logic [31:0]         readdata_d;
  logic [DB_CNT_W-1:0] db_eff_s;
  logic                db_clr_s;
  logic                unused_s;

  assign wr_s = chipselect & ~write_n;

`ifdef DEBOUNCED_PIO_DEBOUNCE_EN
  logic [DB_CNT_W-1:0] db_cnt_q;

  // Debounce count register; a write also restarts every channel's count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt_q <= DB_DEFAULT;
    end else if (wr_s && (address == ADDR_DB_CNT)) begin
      db_cnt_q <= writedata[DB_CNT_W-1:0];
    end else begin
      db_cnt_q <= db_cnt_q;
    end
  end

  assign db_eff_s = db_effective(db_cnt_q);
  assign db_clr_s = wr_s && (address == ADDR_DB_CNT);
  assign unused_s = ^writedata;
`else
  assign db_eff_s = 16'd1;
  assign db_clr_s = 1'b0;
  assign unused_s = ^{writedata, DB_DEFAULT};
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pio_debounce_ch #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_ch (
      .clk_i   (clk),
      .rst_i   (reset),
      .in_i    (in_port[i]),
      .db_eff_i(db_eff_s),
      .db_clr_i(db_clr_s),
      .stable_o(stable_s[i]),
      .rise_o  (rise_s[i]),
      .fall_o  (fall_s[i])
    );
  end

  // Plain read/write control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_en_q  <= {WIDTH{1'b0}};
      fall_en_q  <= {WIDTH{1'b0}};
      irq_mask_q <= {WIDTH{1'b0}};
    end else if (wr_s) begin
      case (address)
        ADDR_RISE_EN:  rise_en_q  <= writedata[WIDTH-1:0];
        ADDR_FALL_EN:  fall_en_q  <= writedata[WIDTH-1:0];
        ADDR_IRQ_MASK: irq_mask_q <= writedata[WIDTH-1:0];
        default: begin
          rise_en_q  <= rise_en_q;
          fall_en_q  <= fall_en_q;
          irq_mask_q <= irq_mask_q;
        end
      endcase
    end else begin
      rise_en_q  <= rise_en_q;
      fall_en_q  <= fall_en_q;
      irq_mask_q <= irq_mask_q;
    end
  end

  // New edges are OR-ed in after the W1C clear so a same-cycle edge survives.
  always_comb begin
    edge_cap_d = edge_cap_q;
    if (wr_s && (address == ADDR_EDGE_CAP)) begin
      edge_cap_d = edge_cap_q & ~writedata[WIDTH-1:0];
    end else begin
      edge_cap_d = edge_cap_q;
    end
    edge_cap_d = edge_cap_d | (rise_s & rise_en_q) | (fall_s & fall_en_q);
  end

  // Edge capture register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_cap_q <= {WIDTH{1'b0}};
    end else begin
      edge_cap_q <= edge_cap_d;
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    readdata_d = 32'd0;
    case (address)
      ADDR_DATA:     readdata_d = 32'(stable_s);
      ADDR_RISE_EN:  readdata_d = 32'(rise_en_q);
      ADDR_IRQ_MASK: readdata_d = 32'(irq_mask_q);
      ADDR_EDGE_CAP: readdata_d = 32'(edge_cap_q);
      ADDR_FALL_EN:  readdata_d = 32'(fall_en_q);
`ifdef DEBOUNCED_PIO_DEBOUNCE_EN
      ADDR_DB_CNT:   readdata_d = {16'd0, db_cnt_q};
`else
      ADDR_DB_CNT:   readdata_d = 32'd0;
`endif
      default:       readdata_d = 32'd0;
    endcase
  end

  // Registered read data, one-cycle latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_q <= 32'd0;
    end else begin
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_debounced_pio_in.sv
// Directed, table-driven bench for debounced_pio_in; expectations adapt to
// whether DEBOUNCED_PIO_DEBOUNCE_EN is defined.
module tb_debounced_pio_in;
  import debounced_pio_pkg::*;

  localparam int          WIDTH  = 8;
  localparam int          SYNC   = 2;
  localparam logic [15:0] DB_DEF = 16'd1000;
`ifdef DEBOUNCED_PIO_DEBOUNCE_EN
  localparam bit DB_ON = 1'b1;
`else
  localparam bit DB_ON = 1'b0;
`endif
  localparam int DB_N = 4;
  localparam int LAT  = SYNC + (DB_ON ? DB_N : 0) + 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [2:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [2:0]  addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[7];

  debounced_pio_in #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC),
    .DB_DEFAULT(DB_DEF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .in_port   (in_port),
    .readdata  (readdata),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] seen;
    logic [31:0] glitch_exp;

    glitch_exp = DB_ON ? 32'd0 : 32'd1;
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = '0;

    tbl[0] = '{ADDR_RISE_EN,  1'b1, 32'h0000_00A5, 32'h0000_00A5};
    tbl[1] = '{ADDR_FALL_EN,  1'b1, 32'h0000_003C, 32'h0000_003C};
    tbl[2] = '{ADDR_IRQ_MASK, 1'b1, 32'hFFFF_FFFF, 32'h0000_00FF};
    tbl[3] = '{ADDR_DATA,     1'b1, 32'h0000_00FF, 32'h0000_0000};
    tbl[4] = '{3'd6,          1'b1, 32'h0000_0123, 32'h0000_0000};
    tbl[5] = '{3'd7,          1'b0, 32'h0000_0000, 32'h0000_0000};
    tbl[6] = '{ADDR_DB_CNT,   1'b1, 32'h0001_2345, DB_ON ? 32'h0000_2345 : 32'h0000_0000};

    tick(3);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    tick(1);
    rd(ADDR_DATA, d);     check("rst_data", d, 32'd0);
    rd(ADDR_RISE_EN, d);  check("rst_rise_en", d, 32'd0);
    rd(ADDR_IRQ_MASK, d); check("rst_irq_mask", d, 32'd0);
    rd(ADDR_EDGE_CAP, d); check("rst_edge_cap", d, 32'd0);
    rd(ADDR_FALL_EN, d);  check("rst_fall_en", d, 32'd0);
    rd(ADDR_DB_CNT, d);   check("rst_db_cnt", d, DB_ON ? 32'(DB_DEF) : 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
      rd(tbl[i].addr, d);
      check($sformatf("vec%0d", i), d, tbl[i].exp);
    end

    // Scenario 1: rise on bit 0, exact latency to irq.
    wr(ADDR_DB_CNT, 32'd4);
    wr(ADDR_RISE_EN, 32'h01);
    wr(ADDR_FALL_EN, 32'h00);
    wr(ADDR_IRQ_MASK, 32'h01);
    address = ADDR_EDGE_CAP;
    in_port = 8'h01;
    tick(LAT - 1);
    check("s1_irq_early", {31'd0, irq}, 32'd0);
    tick(1);
    check("s1_irq_on_time", {31'd0, irq}, 32'd1);
    rd(ADDR_EDGE_CAP, d); check("s1_edge_cap", d, 32'h01);
    rd(ADDR_DATA, d);     check("s1_data", d, 32'h01);
    wr(ADDR_EDGE_CAP, 32'h01);
    check("s1_irq_cleared", {31'd0, irq}, 32'd0);

    // Scenario 2: a 3-cycle glitch on bit 0.
    in_port = 8'h00;
    tick(LAT + 3);
    wr(ADDR_EDGE_CAP, 32'h01);
    rd(ADDR_DATA, d);     check("s2_data_low", d, 32'h00);
    seen = 32'd0;
    address = ADDR_DATA;
    in_port = 8'h01;
    for (int k = 0; k < 3; k++) begin tick(1); seen = seen | readdata; end
    in_port = 8'h00;
    for (int k = 0; k < LAT + 5; k++) begin tick(1); seen = seen | readdata; end
    check("s2_data_seen", seen, glitch_exp);
    check("s2_irq", {31'd0, irq}, glitch_exp);
    rd(ADDR_EDGE_CAP, d); check("s2_edge_cap", d, glitch_exp);
    wr(ADDR_EDGE_CAP, 32'hFF);

    // Scenario 3: fall-only capture on bit 7.
    wr(ADDR_RISE_EN, 32'h00);
    wr(ADDR_FALL_EN, 32'h80);
    wr(ADDR_IRQ_MASK, 32'h80);
    in_port = 8'h80;
    tick(LAT + 3);
    rd(ADDR_EDGE_CAP, d); check("s3_no_rise_cap", d, 32'h00);
    rd(ADDR_DATA, d);     check("s3_data_high", d, 32'h80);
    in_port = 8'h00;
    tick(LAT + 3);
    rd(ADDR_EDGE_CAP, d); check("s3_fall_cap", d, 32'h80);
    check("s3_irq", {31'd0, irq}, 32'd1);
    wr(ADDR_EDGE_CAP, 32'h80);
    wr(ADDR_FALL_EN, 32'h00);

    // Scenario 4: W1C write lands on the same edge as a new bit-0 capture.
    wr(ADDR_RISE_EN, 32'h01);
    wr(ADDR_IRQ_MASK, 32'h01);
    in_port = 8'h01;
    tick(LAT - 1);
    wr(ADDR_EDGE_CAP, 32'h01);
    check("s4_irq_kept", {31'd0, irq}, 32'd1);
    rd(ADDR_EDGE_CAP, d); check("s4_edge_cap_kept", d, 32'h01);

    // Scenario 5: partial W1C of 0x07 by 0x05.
    wr(ADDR_EDGE_CAP, 32'hFF);
    wr(ADDR_RISE_EN, 32'h07);
    wr(ADDR_FALL_EN, 32'h07);
    wr(ADDR_IRQ_MASK, 32'h02);
    in_port = 8'h06;
    tick(LAT + 3);
    rd(ADDR_EDGE_CAP, d); check("s5_cap_all", d, 32'h07);
    wr(ADDR_EDGE_CAP, 32'h05);
    rd(ADDR_EDGE_CAP, d); check("s5_cap_after", d, 32'h02);
    check("s5_irq_masked_in", {31'd0, irq}, 32'd1);
    wr(ADDR_IRQ_MASK, 32'h01);
    check("s5_irq_masked_out", {31'd0, irq}, 32'd0);

    // Scenario 6: reset in the middle of a count.
    wr(ADDR_EDGE_CAP, 32'hFF);
    wr(ADDR_RISE_EN, 32'hFF);
    wr(ADDR_FALL_EN, 32'hFF);
    wr(ADDR_IRQ_MASK, 32'hFF);
    in_port = 8'h0E;
    tick(2);
    reset = 1'b1;
    tick(3);
    in_port = 8'h00;
    check("s6_rst_readdata", readdata, 32'd0);
    check("s6_rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    tick(LAT + 5);
    check("s6_irq_after", {31'd0, irq}, 32'd0);
    rd(ADDR_DATA, d);     check("s6_data", d, 32'd0);
    rd(ADDR_RISE_EN, d);  check("s6_rise_en", d, 32'd0);
    rd(ADDR_IRQ_MASK, d); check("s6_irq_mask", d, 32'd0);
    rd(ADDR_EDGE_CAP, d); check("s6_edge_cap", d, 32'd0);
    rd(ADDR_FALL_EN, d);  check("s6_fall_en", d, 32'd0);
    rd(ADDR_DB_CNT, d);   check("s6_db_cnt", d, DB_ON ? 32'(DB_DEF) : 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
